switch_matrix_cfg_loader: RTL and testbench

SWITCH_MATRIX_CFG_LOADER -- requirements
Module: switch_matrix_cfg_loader

---
 rtl/sm_cfg_pkg.sv | 28 ++
 rtl/switch_matrix_cfg_loader.sv | 113 +++++++++++
 tb/tb_switch_matrix_cfg_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sm_cfg_pkg.sv
// Shared constants, FSM state type and select-code helper for the
// switch-matrix configuration loader.
package sm_cfg_pkg;

   localparam int unsigned CHANNEL_WIDTH = 8;
   localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
   localparam logic [1:0]  ILLEGAL_SEL   = 2'b11;
   localparam int unsigned DATA_BYTES    = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      COMMIT,
      ERROR
   } state_t;

   // A byte carries four 2-bit mux selects; 2'b11 has no input behind it.
   function automatic logic has_illegal(input logic [7:0] b);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (b[2*i +: 2] == ILLEGAL_SEL) r = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/switch_matrix_cfg_loader.sv
// Byte-stream loader for switch_matrix mux selects: sync, four data bytes,
// XOR checksum; commits all four sides atomically or rejects the frame.
module switch_matrix_cfg_loader
   import sm_cfg_pkg::*;
#(
   parameter int unsigned channel_width = CHANNEL_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   input  logic [7:0]               cfg_data,
   output logic                     cfg_ready,
   input  logic                     cfg_abort,
   output logic [channel_width-1:0] ctrl_left,
   output logic [channel_width-1:0] ctrl_right,
   output logic [channel_width-1:0] ctrl_top,
   output logic [channel_width-1:0] ctrl_bottom,
   output logic                     cfg_loaded,
   output logic                     cfg_done,
   output logic                     cfg_err
);

   state_t     r_state, w_next;
   logic [1:0] r_cnt;
   logic [7:0] r_xor;
   logic [7:0] r_shadow [DATA_BYTES];

   logic w_ready, w_xfer, w_abort, w_sum_ok, w_illegal, w_commit;

   // Gated by rst_n so the loader never advertises readiness while held in reset.
   assign w_ready   = rst_n & ((r_state == IDLE) | (r_state == LOAD) | (r_state == CHECK));
   assign cfg_ready = w_ready;
   assign w_xfer    = cfg_valid & w_ready;
   assign w_abort   = cfg_abort & ((r_state == LOAD) | (r_state == CHECK));
   assign w_sum_ok  = (cfg_data == r_xor);
   assign w_commit  = (r_state == CHECK) & w_xfer & ~cfg_abort & w_sum_ok & ~w_illegal;

   always_comb begin
      w_illegal = 1'b0;
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
         w_illegal = w_illegal | has_illegal(r_shadow[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      cfg_done = 1'b0;
      cfg_err  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_xfer && (cfg_data == SYNC_BYTE)) w_next = LOAD;
         end
         LOAD: begin
            if (w_abort)                                       w_next = IDLE;
            else if (w_xfer && (r_cnt == 2'(DATA_BYTES - 1))) w_next = CHECK;
         end
         CHECK: begin
            if (w_abort)     w_next = IDLE;
            else if (w_xfer) w_next = (w_sum_ok && !w_illegal) ? COMMIT : ERROR;
         end
         COMMIT: begin
            cfg_done = 1'b1;
            w_next   = IDLE;
         end
         ERROR: begin
            cfg_err = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Outputs load on the checksum edge so they are valid alongside cfg_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_xor       <= '0;
         for (int unsigned i = 0; i < DATA_BYTES; i++) r_shadow[i] <= '0;
         ctrl_left   <= '0;
         ctrl_right  <= '0;
         ctrl_top    <= '0;
         ctrl_bottom <= '0;
         cfg_loaded  <= 1'b0;
      end else if (w_abort) begin
         r_cnt <= '0;
         r_xor <= '0;
         for (int unsigned i = 0; i < DATA_BYTES; i++) r_shadow[i] <= '0;
      end else begin
         if ((r_state == IDLE) && w_xfer && (cfg_data == SYNC_BYTE)) begin
            r_cnt <= '0;
            r_xor <= '0;
         end
         if ((r_state == LOAD) && w_xfer) begin
            r_shadow[r_cnt] <= cfg_data;
            r_xor           <= r_xor ^ cfg_data;
            r_cnt           <= r_cnt + 2'd1;
         end
         if (w_commit) begin
            ctrl_left   <= channel_width'(r_shadow[0]);
            ctrl_right  <= channel_width'(r_shadow[1]);
            ctrl_top    <= channel_width'(r_shadow[2]);
            ctrl_bottom <= channel_width'(r_shadow[3]);
            cfg_loaded  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_switch_matrix_cfg_loader.sv
// Directed bench for switch_matrix_cfg_loader: commit, checksum/illegal-code
// rejects, dropped pre-sync bytes, throttled valid, abort and mid-frame reset.
module tb_switch_matrix_cfg_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_data = 8'h00;
   logic       cfg_abort = 1'b0;
   logic       cfg_ready, cfg_loaded, cfg_done, cfg_err;
   logic [7:0] ctrl_left, ctrl_right, ctrl_top, ctrl_bottom;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_err = 0;
   int done0, err0;

   switch_matrix_cfg_loader #(.channel_width(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_data   (cfg_data),
      .cfg_ready  (cfg_ready),
      .cfg_abort  (cfg_abort),
      .ctrl_left  (ctrl_left),
      .ctrl_right (ctrl_right),
      .ctrl_top   (ctrl_top),
      .ctrl_bottom(ctrl_bottom),
      .cfg_loaded (cfg_loaded),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cfg_done) n_done++;
      if (cfg_err)  n_err++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_ctrl(input string tag, input logic [7:0] l, input logic [7:0] r,
                             input logic [7:0] t, input logic [7:0] b);
      check({tag, "_ctrl"}, {ctrl_left, ctrl_right, ctrl_top, ctrl_bottom}, {l, r, t, b});
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int unsigned waited;
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = b;
      waited    = 0;
      while (!cfg_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!cfg_ready) check("ready_timeout", 32'(cfg_ready), 32'd1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_data  = 8'hA5;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input logic [7:0] ck, input bit gap);
      send_byte(d0, gap);
      send_byte(d1, gap);
      send_byte(d2, gap);
      send_byte(d3, gap);
      send_byte(ck, 1'b0);
   endtask

   // Checks cycle N+1 and N+2 after the checksum transfer.
   task automatic expect_result(input string tag, input bit ok, input logic [7:0] l,
                                input logic [7:0] r, input logic [7:0] t, input logic [7:0] b);
      @(negedge clk);
      check({tag, "_done_n1"}, 32'(cfg_done), 32'(ok));
      check({tag, "_err_n1"}, 32'(cfg_err), 32'(!ok));
      check({tag, "_ready_n1"}, 32'(cfg_ready), 32'd0);
      check_ctrl(tag, l, r, t, b);
      @(negedge clk);
      check({tag, "_ready_n2"}, 32'(cfg_ready), 32'd1);
      check({tag, "_pulses"}, {16'(n_done - done0), 16'(n_err - err0)}, {16'(ok), 16'(!ok)});
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ctrl", {ctrl_left, ctrl_right, ctrl_top, ctrl_bottom}, 32'h0);
      check("rst_flags", {cfg_loaded, cfg_done, cfg_err, cfg_ready}, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rel_ready", 32'(cfg_ready), 32'd1);

      // Good frame
      done0 = n_done; err0 = n_err;
      send_byte(8'hA5, 1'b0);
      send_frame(8'h24, 8'h12, 8'h09, 8'h00, 8'h3F, 1'b0);
      expect_result("good", 1'b1, 8'h24, 8'h12, 8'h09, 8'h00);
      check("good_loaded", 32'(cfg_loaded), 32'd1);

      // Bad checksum
      done0 = n_done; err0 = n_err;
      send_byte(8'hA5, 1'b0);
      send_frame(8'h24, 8'h12, 8'h09, 8'h00, 8'h3E, 1'b0);
      expect_result("badsum", 1'b0, 8'h24, 8'h12, 8'h09, 8'h00);

      // Illegal select with matching checksum
      done0 = n_done; err0 = n_err;
      send_byte(8'hA5, 1'b0);
      send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0);
      expect_result("illegal", 1'b0, 8'h24, 8'h12, 8'h09, 8'h00);

      // Pre-sync byte dropped, valid toggling each cycle
      done0 = n_done; err0 = n_err;
      send_byte(8'h11, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_frame(8'h10, 8'h04, 8'h01, 8'h20, 8'h35, 1'b1);
      expect_result("toggle", 1'b1, 8'h10, 8'h04, 8'h01, 8'h20);

      // Abort mid-frame, then a full frame
      done0 = n_done; err0 = n_err;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h24, 1'b0);
      send_byte(8'h12, 1'b0);
      @(negedge clk);
      cfg_abort = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 8'h09;
      @(posedge clk);
      #1;
      cfg_abort = 1'b0;
      cfg_valid = 1'b0;
      @(negedge clk);
      check("abort_nopulse", {cfg_done, cfg_err, cfg_ready}, 3'b001);
      check_ctrl("abort_hold", 8'h10, 8'h04, 8'h01, 8'h20);
      send_byte(8'hA5, 1'b0);
      send_frame(8'h06, 8'h18, 8'h21, 8'h02, 8'h3D, 1'b0);
      expect_result("abort", 1'b1, 8'h06, 8'h18, 8'h21, 8'h02);

      // 0xA5 inside a frame is plain data
      done0 = n_done; err0 = n_err;
      send_byte(8'hA5, 1'b0);
      send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 1'b0);
      expect_result("a5data", 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);

      // Reset mid-frame
      send_byte(8'hA5, 1'b0);
      send_byte(8'h24, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", {ctrl_left, ctrl_right, ctrl_top, ctrl_bottom}, 32'h0);
      check("midrst_flags", {cfg_loaded, cfg_done, cfg_err, cfg_ready}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      done0 = n_done; err0 = n_err;
      send_byte(8'hA5, 1'b0);
      send_frame(8'h29, 8'h14, 8'h06, 8'h11, 8'h2A, 1'b0);
      expect_result("postrst", 1'b1, 8'h29, 8'h14, 8'h06, 8'h11);
      check("postrst_loaded", 32'(cfg_loaded), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
